// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator car controller.
package elev_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MAX_FLOORS = 16;
  localparam int TICK_W     = 16;

  // True when any pending floor lies strictly beyond floor in the given direction.
  function automatic logic reqs_ahead(input logic [MAX_FLOORS-1:0] pend,
                                      input int floor, input logic up);
    logic found;
    found = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (pend[i] && (up ? (i > floor) : (i < floor))) found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/elev_tick_timer.sv
// Down-counter shared by travel and door dwell timing; zero flags expiry.
module elev_tick_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] load_val,
  input  logic         load,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller: request bitmap, IDLE/MOVE/DOOR sequencing.
// Optional door-hold input is enabled by defining ELEV_DOOR_HOLD_EN.
module elevator_car_ctrl
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS   = 10,
  parameter int FLOOR_W      = 4,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic                  req_ready,
  output logic                  req_err,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending
);

  // Handshake: a request transfers on any edge where req_valid && req_ready;
  // req_ready is low only during reset, so there is no back-pressure.
  state_t                  state;
  logic                    tick_zero, tick_load, tick_en;
  logic [TICK_W-1:0]       tick_val;
  logic [FLOOR_W-1:0]      nxt_floor;
  logic                    in_range, pend_here, pend_next, blocked;
  logic                    door_restart, dwell_hold, ahead_cur, ahead_nxt;
  logic [NUM_FLOORS-1:0]   set_mask, clr_mask;

  assign req_ready    = ~reset;
  assign in_range     = 32'(req_floor) < NUM_FLOORS;
  assign nxt_floor    = dir_up ? cur_floor + 1'b1 : cur_floor - 1'b1;
  assign blocked      = dir_up ? (cur_floor == FLOOR_W'(NUM_FLOORS-1)) : (cur_floor == '0);
  assign pend_here    = pending[cur_floor];
  assign pend_next    = pending[nxt_floor];
  assign ahead_cur    = reqs_ahead(MAX_FLOORS'(pending), int'(cur_floor), dir_up);
  assign ahead_nxt    = reqs_ahead(MAX_FLOORS'(pending), int'(nxt_floor), dir_up);
  assign door_restart = (state == DOOR) && req_valid && (req_floor == cur_floor);

`ifdef ELEV_DOOR_HOLD_EN
  assign dwell_hold = (state == DOOR) && door_hold;
`else
  assign dwell_hold = 1'b0;
`endif

  always_comb begin
    tick_load = 1'b0;
    tick_en   = 1'b0;
    tick_val  = TICK_W'(TRAVEL_TICKS - 1);
    clr_mask  = '0;
    set_mask  = '0;
    // A same-floor request while the door is open only restarts the dwell.
    if (req_valid && in_range && !door_restart) set_mask = NUM_FLOORS'(1) << req_floor;
    case (state)
      IDLE: begin
        if (pend_here) begin
          clr_mask  = NUM_FLOORS'(1) << cur_floor;
          tick_load = 1'b1;
          tick_val  = TICK_W'(DOOR_TICKS - 1);
        end else if (|pending) begin
          tick_load = 1'b1;
        end
      end
      MOVE: begin
        if (tick_zero) begin
          tick_load = 1'b1;
          if (!blocked && pend_next) begin
            clr_mask = NUM_FLOORS'(1) << nxt_floor;
            tick_val = TICK_W'(DOOR_TICKS - 1);
          end
        end else begin
          tick_en = 1'b1;
        end
      end
      DOOR: begin
        if (door_restart || dwell_hold) begin
          tick_load = 1'b1;
          tick_val  = TICK_W'(DOOR_TICKS - 1);
        end else begin
          tick_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  elev_tick_timer #(.W(TICK_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_val (tick_val),
    .load     (tick_load),
    .en       (tick_en),
    .zero     (tick_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_floor <= '0;
      dir_up    <= DIR_UP;
      pending   <= '0;
      req_err   <= 1'b0;
      arrived   <= 1'b0;
      moving    <= 1'b0;
      door_open <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      req_err <= req_valid && !in_range;
      arrived <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_here) begin
            state     <= DOOR;
            door_open <= 1'b1;
          end else if (|pending) begin
            state  <= MOVE;
            moving <= 1'b1;
            if (!ahead_cur) dir_up <= ~dir_up;
          end
        end
        MOVE: begin
          if (tick_zero) begin
            // Stepping past an end floor is impossible; turn around instead.
            if (blocked) begin
              dir_up <= ~dir_up;
            end else begin
              cur_floor <= nxt_floor;
              if (pend_next) begin
                state     <= DOOR;
                moving    <= 1'b0;
                door_open <= 1'b1;
                arrived   <= 1'b1;
              end else if (!ahead_nxt) begin
                dir_up <= ~dir_up;
              end
            end
          end
        end
        DOOR: begin
          if (!door_restart && !dwell_hold && tick_zero) begin
            state     <= IDLE;
            door_open <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: a 10-floor and a 16-floor car share one stimulus
// stream; a per-cycle behavioural model plus literal spot checks.
module tb_elevator_car_ctrl;

  localparam int TT = 4;
  localparam int DT = 3;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  typedef struct packed {
    int        floor;
    bit        up;
    bit [15:0] pend;
    int        mode;
    int        left;
    bit        arrived;
    bit        err;
  } model_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_floor = 4'd0;
  logic        door_hold = 1'b0;

  logic        rdy10, err10, mv10, up10, door10, arr10;
  logic [3:0]  cur10;
  logic [9:0]  pend10;
  logic        rdy16, err16, mv16, up16, door16, arr16;
  logic [3:0]  cur16;
  logic [15:0] pend16;

  int checks = 0;
  int errors = 0;
  model_t m10, m16;

  int tbl_f[10] = '{3, 8, 1, 6, 6, 0, 9, 2, 13, 5};
  int tbl_g[10] = '{1, 7, 2, 20, 0, 3, 11, 5, 1, 9};

  always #5 clk = ~clk;

  elevator_car_ctrl #(.NUM_FLOORS(10), .FLOOR_W(4), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) u10 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .req_ready(rdy10), .req_err(err10), .cur_floor(cur10), .moving(mv10),
    .dir_up(up10), .door_open(door10), .arrived(arr10), .pending(pend10)
  );

  elevator_car_ctrl #(.NUM_FLOORS(16), .FLOOR_W(4), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) u16 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .req_ready(rdy16), .req_err(err16), .cur_floor(cur16), .moving(mv16),
    .dir_up(up16), .door_open(door16), .arrived(arr16), .pending(pend16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ahead(bit [15:0] p, int fl, bit up);
    for (int i = 0; i < 16; i++) if (p[i] && (up ? i > fl : i < fl)) return 1'b1;
    return 1'b0;
  endfunction

  // Behaviour stated directly: remaining cycles per phase, floor as an integer.
  function automatic model_t model_next(model_t m, int nf, bit rst, bit v, int f, bit hold);
    model_t n;
    bit set_ok;
    n = m;
    if (rst) begin
      n.floor = 0; n.up = 1'b1; n.pend = '0; n.mode = M_IDLE;
      n.left = 0; n.arrived = 1'b0; n.err = 1'b0;
      return n;
    end
    n.arrived = 1'b0;
    n.err = v && (f >= nf);
    set_ok = v && (f < nf);
    case (m.mode)
      M_IDLE: begin
        if (m.pend[m.floor]) begin
          n.mode = M_DOOR; n.left = DT; n.pend[m.floor] = 1'b0;
        end else if (m.pend != 0) begin
          n.mode = M_MOVE; n.left = TT;
          if (!ahead(m.pend, m.floor, m.up)) n.up = !m.up;
        end
      end
      M_MOVE: begin
        n.left = m.left - 1;
        if (n.left == 0) begin
          n.floor = m.up ? m.floor + 1 : m.floor - 1;
          n.left = TT;
          if (m.pend[n.floor]) begin
            n.mode = M_DOOR; n.left = DT; n.pend[n.floor] = 1'b0; n.arrived = 1'b1;
          end else if (!ahead(m.pend, n.floor, m.up)) begin
            n.up = !m.up;
          end
        end
      end
      default: begin
        if (set_ok && f == m.floor) begin
          n.left = DT; set_ok = 1'b0;
        end else if (hold) begin
          n.left = DT;
        end else begin
          n.left = m.left - 1;
          if (n.left == 0) n.mode = M_IDLE;
        end
      end
    endcase
    if (set_ok) n.pend[f] = 1'b1;
    return n;
  endfunction

  always @(posedge clk) begin
    m10 = model_next(m10, 10, reset, req_valid, int'(req_floor), door_hold);
    m16 = model_next(m16, 16, reset, req_valid, int'(req_floor), door_hold);
  end

  task automatic compare_dut(input string tag, input model_t m, input logic [3:0] cur,
                             input logic mv, input logic up, input logic dop, input logic arr,
                             input logic err, input logic rdy, input logic [15:0] pend);
    check({tag, " cur_floor"}, 32'(cur), 32'(m.floor));
    check({tag, " moving"}, 32'(mv), 32'(m.mode == M_MOVE));
    check({tag, " dir_up"}, 32'(up), 32'(m.up));
    check({tag, " door_open"}, 32'(dop), 32'(m.mode == M_DOOR));
    check({tag, " arrived"}, 32'(arr), 32'(m.arrived));
    check({tag, " req_err"}, 32'(err), 32'(m.err));
    check({tag, " req_ready"}, 32'(rdy), 32'(!reset));
    check({tag, " pending"}, 32'(pend), 32'(m.pend));
  endtask

  always @(posedge clk) begin
    #2;
    compare_dut("u10", m10, cur10, mv10, up10, door10, arr10, err10, rdy10, {6'd0, pend10});
    compare_dut("u16", m16, cur16, mv16, up16, door16, arr16, err16, rdy16, pend16);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req(input int f);
    req_valid = 1'b1;
    req_floor = 4'(f);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    tick(2);
    check("rst cur_floor", 32'(cur10), 32'd0);
    check("rst pending", 32'(pend10), 32'd0);
    check("rst dir_up", 32'(up10), 32'd1);
    check("rst req_ready", 32'(rdy10), 32'd0);
    check("rst moving_door", {30'd0, mv10, door10}, 32'd0);
    reset = 1'b0;

    // Floor 0 to floor 2 with default timing.
    req(2);
    check("a pending", 32'(pend10), 32'h4);
    check("a idle_e0", 32'(mv10), 32'd0);
    tick(1);  check("a move_e1", 32'(mv10), 32'd1);
    tick(4);  check("a floor1_e5", 32'(cur10), 32'd1);
    tick(4);  check("a floor2_e9", 32'(cur10), 32'd2);
    check("a door_e9", 32'(door10), 32'd1);
    check("a arrived_e9", 32'(arr10), 32'd1);
    tick(1);  check("a arrived_e10", 32'(arr10), 32'd0);
    tick(1);  check("a door_e11", 32'(door10), 32'd1);
    tick(1);  check("a closed_e12", 32'(door10), 32'd0);
    check("a idle_e12", 32'(mv10), 32'd0);

    // Move to 3, then a same-floor request while idle, then dwell restart.
    req(3);
    tick(5);  check("b arrive3", 32'(cur10), 32'd3);
    tick(3);  check("b idle3", 32'(door10), 32'd0);
    req(3);
    check("b pend3", 32'(pend10), 32'h8);
    tick(1);  check("b door_open", 32'(door10), 32'd1);
    check("b no_arrived", 32'(arr10), 32'd0);
    check("b bit_clear", 32'(pend10), 32'd0);
    tick(1);
    req(3);
    check("b restart_open", 32'(door10), 32'd1);
    check("b restart_clear", 32'(pend10), 32'd0);
    tick(2);  check("b still_open", 32'(door10), 32'd1);
    tick(1);  check("b closed", 32'(door10), 32'd0);

    // Reverse service order and an out-of-range request.
    reset = 1'b1;
    tick(1);
    check("c rst_floor", 32'(cur10), 32'd0);
    reset = 1'b0;
    req(5);
    tick(13); check("c past2", 32'(cur10), 32'd3);
    req(2);
    check("c pend_2_5", 32'(pend10), 32'h24);
    req(12);
    check("c err_pulse", 32'(err10), 32'd1);
    check("c pend_keep", 32'(pend10), 32'h24);
    check("c u16_accepts12", 32'(pend16), 32'h1024);
    tick(1);  check("c err_drop", 32'(err10), 32'd0);
    tick(5);  check("c at5", 32'(cur10), 32'd5);
    check("c arrived5", 32'(arr10), 32'd1);
    tick(4);  check("c reversed", 32'(up10), 32'd0);
    check("c moving_down", 32'(mv10), 32'd1);
    tick(12); check("c at2", 32'(cur10), 32'd2);
    check("c door2", 32'(door10), 32'd1);
    tick(3);

    // Reset in the middle of a move between 4 and 5.
    req(5);
    tick(9);  check("d at4", 32'(cur10), 32'd4);
    tick(1);
    reset = 1'b1;
    req_valid = 1'b1;
    req_floor = 4'd7;
    tick(1);
    check("d rst_floor", 32'(cur10), 32'd0);
    check("d rst_pend", 32'(pend10), 32'd0);
    check("d rst_moving", 32'(mv10), 32'd0);
    check("d rst_ready", 32'(rdy10), 32'd0);
    tick(1);
    reset = 1'b0;
    req_valid = 1'b0;
    tick(1);
    check("d dropped", 32'(pend10), 32'd0);
    check("d idle", 32'(mv10), 32'd0);

    // Full 16-floor climb with no overflow.
    req(15);
    check("e u10_err", 32'(err10), 32'd1);
    check("e u16_pend", 32'(pend16), 32'h8000);
    tick(60); check("e u16_at14", 32'(cur16), 32'd14);
    check("e u16_moving", 32'(mv16), 32'd1);
    tick(1);  check("e u16_at15", 32'(cur16), 32'd15);
    check("e u16_arrived", 32'(arr16), 32'd1);
    tick(3);  check("e u16_stay15", 32'(cur16), 32'd15);

`ifdef ELEV_DOOR_HOLD_EN
    req(15);
    tick(1);  check("h door_open", 32'(door16), 32'd1);
    door_hold = 1'b1;
    tick(10); check("h held", 32'(door16), 32'd1);
    door_hold = 1'b0;
    tick(2);  check("h after_release", 32'(door16), 32'd1);
    tick(1);  check("h closed", 32'(door16), 32'd0);
`endif

    // Mixed request table, including back-to-back and duplicate floors.
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_floor = 4'(tbl_f[i]);
      @(negedge clk);
      req_valid = 1'b0;
      tick(tbl_g[i]);
    end
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick(1);
      if (!mv10 && !door10 && pend10 == '0 && !mv16 && !door16 && pend16 == '0) done = 1'b1;
    end
    check("drain_idle", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_car_ctrl.md
ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 10, number of served floors (2..16).
REQ-002 Parameter FLOOR_W, default 4, floor index width, SHALL be >= clog2(NUM_FLOORS).
REQ-003 Parameter TRAVEL_TICKS, default 4, clock cycles per one-floor move (>= 1).
REQ-004 Parameter DOOR_TICKS, default 3, clock cycles door stays open (>= 1).
REQ-005 clk  in  1  single system clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  floor request offered this cycle.
REQ-008 req_floor  in  FLOOR_W  requested floor index.
REQ-009 req_ready  out  1  request acceptance; handshake completes when req_valid && req_ready.
REQ-010 req_err  out  1  one-cycle pulse: accepted request had req_floor >= NUM_FLOORS.
REQ-011 cur_floor  out  FLOOR_W  current car floor.
REQ-012 moving  out  1  high in MOVE state.
REQ-013 dir_up  out  1  current/last travel direction, 1 = up.
REQ-014 door_open  out  1  high in DOOR state.
REQ-015 arrived  out  1  one-cycle pulse on the cycle DOOR is entered from MOVE.
REQ-016 pending  out  NUM_FLOORS  bitmap of outstanding requests.

Function
REQ-017 req_ready SHALL be 1 whenever reset is low; requests are never back-pressured.
REQ-018 Accepted in-range request SHALL set pending[req_floor] at that edge; duplicates are idempotent.
REQ-019 Out-of-range request SHALL leave pending unchanged and pulse req_err next cycle.
REQ-020 States: IDLE, MOVE, DOOR; one-hot or encoded, encoding from package.
REQ-021 IDLE: pending[cur_floor] set -> DOOR (bit cleared); else any pending -> MOVE, direction = keep dir_up if requests exist that way, otherwise reverse; else stay.
REQ-022 MOVE: tick counter loads TRAVEL_TICKS-1 on entry and per floor; at zero cur_floor steps +/-1 by dir_up.
REQ-023 On floor step: new floor pending -> DOOR, clear bit, arrived=1; else requests ahead in dir_up -> continue MOVE; else reverse dir_up and continue MOVE.
REQ-024 DOOR: lasts exactly DOOR_TICKS cycles, then IDLE.
REQ-025 Request for cur_floor accepted in DOOR SHALL restart dwell to full DOOR_TICKS and leave bit clear.
REQ-026 Request for cur_floor accepted in MOVE SHALL set the bit (served on a later visit).
REQ-027 cur_floor SHALL never leave 0..NUM_FLOORS-1; no wrap-around.
REQ-028 Set and clear of the same pending bit in one cycle: clear wins only in case REQ-025; otherwise set wins.

Reset
REQ-029 reset SHALL force IDLE, cur_floor=0, dir_up=1, pending=0, tick=0, all pulses 0, door_open=0, moving=0, overriding any state incl. mid-move.
REQ-030 Requests presented while reset is high SHALL be dropped (req_ready=0).

Configuration
REQ-031 Macro ELEV_DOOR_HOLD_EN defined: input door_hold (1 bit) added; while high in DOOR the dwell counter SHALL reload to DOOR_TICKS-1 and door stays open.
REQ-032 Macro undefined: port door_hold absent, dwell is fixed per REQ-024.

Structure
REQ-033 Package elev_pkg SHALL hold state enum (IDLE/MOVE/DOOR) and direction constants DIR_UP/DIR_DOWN.
REQ-034 Sub-module elev_tick_timer (load value, load, enable, zero flag) SHALL implement both travel and dwell countdowns; one instance.

Verification
REQ-035 Defaults, floor 0, request 2 accepted at edge E0 -> MOVE after E1, cur_floor=1 after E5, cur_floor=2 with door_open=1 and arrived=1 after E9, IDLE after E12.
REQ-036 Car at 3 idle, request 3 -> DOOR next edge, arrived stays 0, door open 3 cycles; repeat request 3 during DOOR -> dwell restarts to 3.
REQ-037 Moving up from 0 to 5, request 2 during travel past 2 -> serves 5 first, reverses, stops at 2; request 7 req_floor=12 -> req_err pulse, pending unchanged.
REQ-038 Reset asserted while moving between 4 and 5 -> next cycle cur_floor=0, pending=0, IDLE; request during reset ignored.
REQ-039 ELEV_DOOR_HOLD_EN: door_hold high 10 cycles in DOOR -> door_open held through, closes DOOR_TICKS cycles after release.
REQ-040 NUM_FLOORS=16, FLOOR_W=4: request 15 from 0 -> reaches 15 after 15*TRAVEL_TICKS MOVE cycles, no overflow.
